ad_channel_poller: RTL
======================

# ad_channel_poller

Communication-side consumer of the per-channel peak-data interface. It polls the `fifo_full` flags of `CH_NUM` acquisition channels in round-robin order and drains one full buffer (`BURST_LEN` words) from each ready channel with `rdreq`. It forwards the words as a framed stream with a valid/ready handshake to the uplink formatter. It runs entirely in the 25 MHz communication clock domain that also drives each channel's read side.

## Interface
Parameters:
- `CH_NUM`, 4: number of acquisition channels polled (2..8).
- `BURST_LEN`, 256: words drained per grant; equals the depth of one ping-pong FIFO.
- `CH_W`, 3: width of the channel index; must satisfy 2^`CH_W` ≥ `CH_NUM`.

Ports:
- `clk`  in  1  communication clock; the same clock as every channel's read side.
- `rst_n`  in  1  asynchronous active-low reset.
- `fifo_full`  in  `CH_NUM`  per-channel "buffer ready" level from each channel.
- `ch_data`  in  16*`CH_NUM`  flattened read data; channel i occupies bits [16i+15:16i].
- `rdreq`  out  `CH_NUM`  per-channel read request; at most one bit high at a time.
- `out_data`  out  16  stream data.
- `out_valid`  out  1  stream word valid.
- `out_ready`  in  1  downstream accepts the word when high together with `out_valid`.
- `out_sof`  out  1  first word of a frame; qualified by `out_valid`.
- `out_eof`  out  1  last word of a frame; qualified by `out_valid`.
- `out_ch`  out  `CH_W`  channel index of the current frame.
- `busy`  out  1  high from grant until the frame's last word is accepted.

## Operation
- Read protocol (fixed):
  - `rdreq[i]` sampled high at edge t presents the word on `ch_data[i]` at edge t+1.
  - Read latency is exactly 1 cycle.
- Eligibility:
  - Channel i is eligible when `fifo_full[i]`=1 and its `armed[i]`=1.
  - `armed[i]` resets to 1.
  - It clears when channel i's burst completes.
  - It sets again on any cycle where `fifo_full[i]`=0. This prevents a stale full flag from causing a double read.
- Arbitration:
  - Round-robin, starting from `last_ch+1` modulo `CH_NUM`.
  - The first eligible channel is granted in a single cycle.
  - `last_ch` resets to `CH_NUM-1`, so channel 0 has priority first.
- State machine:
  - IDLE → GRANT when any channel is eligible. Latch the channel index into `out_ch`, clear the word counter, set `busy`.
  - GRANT → HDR (with `POLL_HEADER_EN`) or READ (without).
  - HDR: push header word {8'hA5, 5'b0, ch index zero-extended to 3 bits} into the output buffer, then → READ.
  - READ: issue `rdreq` under the credit rule until `BURST_LEN` requests are issued, then → DRAIN.
  - DRAIN: wait until the last word is accepted downstream. Then clear `armed[ch]`, update `last_ch`, drop `busy`, → IDLE.
- Output buffer:
  - 2-entry FIFO with valid/ready on the output side.
  - Credit rule: `rdreq` may be high in a cycle only if occupancy + in-flight read − (pop this cycle) ≤ 1.
  - Result: zero loss, and full 1 word/cycle throughput when `out_ready` stays high.
- Framing:
  - `out_sof` is on the header word (or on data word 0 without a header).
  - `out_eof` is on data word `BURST_LEN`-1.
  - Header words and data words are counted separately; `BURST_LEN` counts data words only.
- Word counter: `log2(BURST_LEN)+1` bits; never wraps within a frame.
- A `fifo_full` deassertion mid-burst is ignored; the burst always completes `BURST_LEN` reads.

## Timing
- Reset values: `rdreq`=0, `out_valid`=0, `out_sof`=0, `out_eof`=0, `out_data`=0, `out_ch`=0, `busy`=0, state=IDLE, output buffer empty, `armed`=all ones.
- Reset asserted mid-burst: `rdreq` drops immediately (asynchronously) and the partial frame is discarded.
- Eligible flag to first `rdreq`:
  - 2 cycles without header (IDLE→GRANT→READ).
  - 3 cycles with header.
- First data word reaches `out_valid` 1 cycle after its `rdreq`. The output buffer is fall-through-free: registered, adding 1 cycle.
- With `out_ready` constantly high, a frame occupies `BURST_LEN` (+1 with header) consecutive `out_valid` cycles.
- `out_ready` low stalls `rdreq` within 1 cycle. At most 2 words are held.
- Back-to-back frames: at least 1 IDLE cycle between one frame's `out_eof` acceptance and the next grant.

## Configuration
- `POLL_HEADER_EN` defined:
  - Each frame is prefixed by the header word.
  - `out_sof` marks the header.
  - A frame is `BURST_LEN`+1 words.
- `POLL_HEADER_EN` undefined:
  - No HDR state.
  - `out_sof` marks data word 0.
  - A frame is `BURST_LEN` words.

## Test plan
- Single channel, `fifo_full[2]`=1, `out_ready`=1, header on → 257 words: header 16'hA502, then 256 data words matching channel 2's model in order. `rdreq[2]` is high for exactly 256 cycles.
- All four channels full simultaneously → frames granted in order 0,1,2,3. `out_ch` matches each frame, and no `rdreq` bits overlap.
- `fifo_full[1]` held high after a burst with no low cycle → no second grant of channel 1. After one low cycle and then high again → channel 1 is granted again.
- `out_ready` toggled randomly at 50% → no lost or duplicated words, `rdreq` never violates the credit rule, and buffer occupancy never exceeds 2.
- `rst_n` pulsed low at data word 100 → all outputs return to reset values immediately. After release, the first grant goes to channel 0 and a full frame is delivered.
- Header off, `BURST_LEN`=4 → `out_sof` on word 0, `out_eof` on word 3, and `busy` low 1 cycle after word 3 is accepted.

Source files
------------

// File: rtl/ad_channel_poller.sv
// ad_channel_poller
// Round-robin poller for CH_NUM acquisition channels. Each channel that reports
// a full ping-pong buffer is drained of BURST_LEN words. The words go out as a
// framed valid/ready stream. Everything runs on the communication clock.
//
// Optional feature: define POLL_HEADER_EN to prefix each frame with a header
// word {8'hA5, 5'b0, ch[2:0]}. With the macro undefined, frames carry data only.
//
// Ports
//   clk, rst_n     communication clock, async active-low reset
//   fifo_full      per-channel buffer-ready level
//   ch_data        flattened read data, channel i at [16i+15:16i], 1-cycle latency
//   rdreq          per-channel read request, one-hot or zero
//   out_data/out_valid/out_ready  output stream handshake
//   out_sof/out_eof               frame delimiters, qualified by out_valid
//   out_ch         channel index of the current frame
//   busy           high from grant until the last word of the frame is accepted
//
// state   | meaning
// S_IDLE  | waiting for an eligible channel
// S_GRANT | channel latched, counters cleared
// S_HDR   | header word launched (POLL_HEADER_EN only)
// S_READ  | issuing rdreq under the credit rule
// S_DRAIN | waiting for the last word to be accepted
module ad_channel_poller #(
    parameter int CH_NUM    = 4,
    parameter int BURST_LEN = 256,
    parameter int CH_W      = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CH_NUM-1:0]    fifo_full,
    input  logic [16*CH_NUM-1:0] ch_data,
    output logic [CH_NUM-1:0]    rdreq,
    output logic [15:0]          out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [CH_W-1:0]      out_ch,
    output logic                 busy
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
`ifdef POLL_HEADER_EN
        S_HDR,
`endif
        S_READ,
        S_DRAIN
    } state_t;

    typedef struct packed {
        logic        sof;
        logic        eof;
        logic [15:0] data;
    } entry_t;

    state_t           r_state, w_state_nxt;
    logic [CH_W-1:0]  r_ch, r_last_ch, w_grant_ch;
    logic [CH_NUM-1:0] r_armed, w_elig, w_rot, w_rdreq;
    logic             w_any_elig;
    logic [CNT_W-1:0] r_req_cnt, r_rcv_cnt;
    logic             r_inflight, r_infl_hdr, w_hdr_issue;
    entry_t           r_buf0, r_buf1, w_push_entry;
    logic [1:0]       r_occ;
    logic [2:0]       w_level;
    logic             r_busy;
    logic             w_pop, w_rd, w_done;
    logic [15:0]      w_sel_data;

    assign w_elig = fifo_full & r_armed;

    // Rotate so that bit 0 is the channel after the last one served.
    always_comb begin
        w_rot      = CH_NUM'({w_elig, w_elig} >> (int'(r_last_ch) + 1));
        w_any_elig = 1'b0;
        w_grant_ch = '0;
        for (int j = 0; j < CH_NUM; j++) begin
            if (!w_any_elig && w_rot[j]) begin
                w_any_elig = 1'b1;
                w_grant_ch = CH_W'((int'(r_last_ch) + 1 + j) % CH_NUM);
            end
        end
    end

    assign w_pop   = out_valid & out_ready;
    // Words held plus the word in flight, after this cycle's pop.
    assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd    = (r_state == S_READ) && (w_level <= 3'd1);
    assign w_done  = (r_state == S_DRAIN) && w_pop && r_buf0.eof;

`ifdef POLL_HEADER_EN
    assign w_hdr_issue = (r_state == S_HDR);
`else
    assign w_hdr_issue = 1'b0;
`endif

    always_comb begin
        w_sel_data = '0;
        w_rdreq    = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (r_ch == CH_W'(i)) begin
                w_sel_data = ch_data[16*i +: 16];
                w_rdreq[i] = w_rd;
            end
        end
    end

    assign rdreq = w_rdreq;

    always_comb begin
        w_push_entry.sof  = (r_rcv_cnt == '0);
        w_push_entry.eof  = (r_rcv_cnt == LAST_CNT);
        w_push_entry.data = w_sel_data;
`ifdef POLL_HEADER_EN
        // The header travels through the in-flight slot like a read, so it
        // lands in the buffer just ahead of data word 0 with no bubble.
        w_push_entry.sof = 1'b0;
        if (r_infl_hdr) begin
            w_push_entry.sof  = 1'b1;
            w_push_entry.eof  = 1'b0;
            w_push_entry.data = {8'hA5, 5'b0, 3'(r_ch)};
        end
`endif
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any_elig) w_state_nxt = S_GRANT;
`ifdef POLL_HEADER_EN
            S_GRANT: w_state_nxt = S_HDR;
            S_HDR:   w_state_nxt = S_READ;
`else
            S_GRANT: w_state_nxt = S_READ;
`endif
            S_READ:  if (w_rd && r_req_cnt == LAST_CNT) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ch       <= '0;
            r_last_ch  <= CH_W'(CH_NUM - 1);
            r_busy     <= 1'b0;
            r_armed    <= '1;
            r_req_cnt  <= '0;
            r_rcv_cnt  <= '0;
            r_inflight <= 1'b0;
            r_infl_hdr <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            if (r_state == S_IDLE && w_any_elig) begin
                r_ch      <= w_grant_ch;
                r_busy    <= 1'b1;
                r_req_cnt <= '0;
                r_rcv_cnt <= '0;
            end else begin
                if (w_rd) r_req_cnt <= r_req_cnt + 1'b1;
                if (r_inflight && !r_infl_hdr) r_rcv_cnt <= r_rcv_cnt + 1'b1;
            end
            r_inflight <= w_rd | w_hdr_issue;
            r_infl_hdr <= w_hdr_issue;
            if (w_done) begin
                r_last_ch <= r_ch;
                r_busy    <= 1'b0;
            end
            // A low flag re-arms; otherwise a finished burst disarms until it drops.
            for (int i = 0; i < CH_NUM; i++) begin
                if (!fifo_full[i])                       r_armed[i] <= 1'b1;
                else if (w_done && r_ch == CH_W'(i))     r_armed[i] <= 1'b0;
            end
            case ({r_inflight, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_buf0 <= w_push_entry;
                    else               r_buf1 <= w_push_entry;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= w_push_entry;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_buf0.data;
    assign out_sof   = r_buf0.sof & out_valid;
    assign out_eof   = r_buf0.eof & out_valid;
    assign out_ch    = r_ch;
    assign busy      = r_busy;

endmodule
